// File: rtl/sram_wem_port_ctrl_if.sv
// Request/response bus between a load-store master and sram_wem_port_ctrl.
// The master drives requests and response ready; the controller (slave) drives
// request ready and the response channel.
interface sram_wem_port_ctrl_if #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDITH = 32
);
    localparam int MASK_W = DATA_WIDITH / 8;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [MASK_W-1:0]      req_wem;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDITH-1:0] req_wdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDITH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_wem, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_wem, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_wem_port_ctrl.sv
// sram_wem_port_ctrl: valid/ready byte-masked request front-end for one
// SingleRAM_WEM_FPGA instance. Requests become single-cycle RAM strobes in the
// accept cycle; read data is captured after 1 or 2 cycles (ram_pipen) and
// returned through a response FIFO whose free slots are pre-reserved by credits,
// so consumer back-pressure can never drop a response.
// Optional feature macro: SRAM_PORT_PERF_EN (adds saturating 16-bit counters of
// accepted reads, accepted writes and stalled request cycles).
module sram_wem_port_ctrl #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDITH = 32,
    parameter int RSP_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_pipen_i,
    output logic                     idle_o,
    sram_wem_port_ctrl_if.slave      bus,
    output logic                     ram_en_o,
    output logic                     ram_we_o,
    output logic [DATA_WIDITH/8-1:0] ram_wem_o,
    output logic [ADDR_WIDTH-1:0]    ram_addr_o,
    output logic [DATA_WIDITH-1:0]   ram_din_o,
    input  logic [DATA_WIDITH-1:0]   ram_dout_i,
    output logic                     ram_pipen_o
`ifdef SRAM_PORT_PERF_EN
    ,
    output logic [15:0]              perf_rd_cnt_o,
    output logic [15:0]              perf_wr_cnt_o,
    output logic [15:0]              perf_stall_cnt_o
`endif
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RSP_DEPTH);

    // Control state
    logic                   rdy_en_q;
    logic [CNT_W-1:0]       credit_q;
    logic [CNT_W-1:0]       credit_d;
    logic                   rd_vld_p1_q;
    logic                   rd_vld_p2_q;
    logic                   ram_pipen_q;
    logic [PTR_W:0]         wr_ptr_q;
    logic [PTR_W:0]         rd_ptr_q;

    // Response storage (data only, never reset)
    logic [DATA_WIDITH-1:0] fifo_mem [RSP_DEPTH];

    // Combinational handshake terms
    logic tags_empty;
    logic pipen_update;
    logic req_ready;
    logic accept;
    logic acc_rd;
    logic push;
    logic pop;
    logic fifo_empty;
    logic fifo_full;

    // Handshake, latency-tag and FIFO status decode
    always_comb begin
        tags_empty   = !rd_vld_p1_q && !rd_vld_p2_q;
        // The RAM pipeline setting only switches with nothing in flight, so every
        // read completes with the latency it was issued under.
        pipen_update = (cfg_pipen_i != ram_pipen_q) && tags_empty;
        req_ready    = rdy_en_q && (credit_q != '0) && !pipen_update;
        accept       = bus.req_valid && req_ready;
        acc_rd       = accept && !bus.req_we;
        push         = ram_pipen_q ? rd_vld_p2_q : rd_vld_p1_q;
        fifo_empty   = (wr_ptr_q == rd_ptr_q);
        fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop          = !fifo_empty && bus.rsp_ready;
    end

    // Credits: one consumed per accepted read, one returned per FIFO pop
    always_comb begin
        credit_d = credit_q;
        if (pop && !acc_rd) begin
            credit_d = credit_q + 1'b1;
        end else if (!pop && acc_rd) begin
            credit_d = credit_q - 1'b1;
        end
    end

    // Control registers: ready enable, credits, latency tags, pipen, FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            credit_q    <= CREDIT_MAX;
            rd_vld_p1_q <= 1'b0;
            rd_vld_p2_q <= 1'b0;
            ram_pipen_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            rdy_en_q    <= 1'b1;
            credit_q    <= credit_d;
            // -- tag stage p0 -> p1: read accepted this cycle
            rd_vld_p1_q <= acc_rd;
            // -- tag stage p1 -> p2: only used with the extra RAM output register
            rd_vld_p2_q <= ram_pipen_q && rd_vld_p1_q;
            if (pipen_update) begin
                ram_pipen_q <= cfg_pipen_i;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Capture returning RAM data into the response FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= ram_dout_i;
        end
    end

    // Credits reserve a FIFO slot for every read before it is accepted
    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
    assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CREDIT_MAX);

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = !fifo_empty;
    // Head entry is held until popped; zero when nothing is queued
    assign bus.rsp_rdata = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];

    assign ram_en_o    = accept;
    assign ram_we_o    = accept && bus.req_we;
    assign ram_wem_o   = ram_we_o ? bus.req_wem : '0;
    assign ram_addr_o  = bus.req_addr;
    assign ram_din_o   = bus.req_wdata;
    assign ram_pipen_o = ram_pipen_q;

    assign idle_o = tags_empty && fifo_empty;

`ifdef SRAM_PORT_PERF_EN
    logic [15:0] perf_rd_q;
    logic [15:0] perf_wr_q;
    logic [15:0] perf_stall_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    // Saturating activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= sat_inc(perf_rd_q, acc_rd);
            perf_wr_q    <= sat_inc(perf_wr_q, accept && bus.req_we);
            perf_stall_q <= sat_inc(perf_stall_q, bus.req_valid && !req_ready);
        end
    end

    assign perf_rd_cnt_o    = perf_rd_q;
    assign perf_wr_cnt_o    = perf_wr_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_sram_wem_port_ctrl.sv
// Directed bench for sram_wem_port_ctrl with a byte-masked RAM model that
// honours ram_pipen (1 or 2 cycle read latency).
module tb_sram_wem_port_ctrl;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_pipen = 1'b0;
    logic          idle;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_pipen;

    logic rst_nxt = 1'b0;
    logic cfg_nxt = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_wem_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDITH(DW)) bus_if ();

    sram_wem_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDITH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_pipen_i (cfg_pipen),
        .idle_o      (idle),
        .bus         (bus_if),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_wem_o   (ram_wem),
        .ram_addr_o  (ram_addr),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout),
        .ram_pipen_o (ram_pipen)
    );

    // RAM model: synchronous byte-masked write, registered read, optional output register
    logic [DW-1:0] ram_mem [2**AW];
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end
            dout1 <= ram_mem[ram_addr];
        end
        dout2 <= dout1;
    end
    assign ram_dout = ram_pipen ? dout2 : dout1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs change at the falling edge, outputs settle 1 time unit later
    task automatic drive(input logic v, input logic we, input logic [3:0] wem,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic rr);
        @(negedge clk);
        rst_n               = rst_nxt;
        cfg_pipen           = cfg_nxt;
        bus_if.req_valid    = v;
        bus_if.req_we       = we;
        bus_if.req_wem      = wem;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wd;
        bus_if.rsp_ready    = rr;
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [3:0] wem);
        drive(1'b1, 1'b1, wem, addr, wd, 1'b1);
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic rr);
        drive(1'b1, 1'b0, 4'hF, addr, 32'h0, rr);
    endtask

    task automatic nop(input logic rr);
        drive(1'b0, 1'b0, 4'h0, '0, 32'h0, rr);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_wem   = 4'h0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.rsp_ready = 1'b1;

        // Reset state, with a write request presented during reset
        drive(1'b1, 1'b1, 4'hF, '0, 32'h0, 1'b1);
        chk("rst_req_ready", bus_if.req_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wem", ram_wem, 0);
        chk("rst_rsp_valid", bus_if.rsp_valid, 0);
        chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ram_pipen", ram_pipen, 0);
        rst_nxt = 1'b1;
        nop(1'b1);
        chk("release_cycle_ready", bus_if.req_ready, 0);
        nop(1'b1);
        chk("post_reset_ready", bus_if.req_ready, 1);

        // pipen=0: full write then read back, response 2 cycles after accept
        wr(11'd5, 32'hA5A5_1234, 4'hF);
        chk("t1_wr_en", ram_en, 1);
        chk("t1_wr_we", ram_we, 1);
        chk("t1_wr_wem", ram_wem, 4'hF);
        chk("t1_wr_addr", ram_addr, 5);
        chk("t1_wr_din", ram_din, 32'hA5A5_1234);
        rd(11'd5, 1'b1);
        chk("t1_rd_en", ram_en, 1);
        chk("t1_rd_we", ram_we, 0);
        chk("t1_rd_wem", ram_wem, 0);
        nop(1'b1);
        chk("t1_rsp_early", bus_if.rsp_valid, 0);
        chk("t1_busy", idle, 0);
        nop(1'b1);
        chk("t1_rsp_valid", bus_if.rsp_valid, 1);
        chk("t1_rsp_data", bus_if.rsp_rdata, 32'hA5A5_1234);
        nop(1'b1);
        chk("t1_rsp_done", bus_if.rsp_valid, 0);
        chk("t1_idle", idle, 1);

        // Back-pressure: preload 16..21, then 6 reads with rsp_ready low
        for (int i = 0; i < 6; i++) begin
            wr(AW'(16 + i), 32'hCAFE_0010 + 32'(i), 4'hF);
            chk("t3_preload_we", ram_we, 1);
        end
        for (int i = 0; i < 4; i++) begin
            rd(AW'(16 + i), 1'b0);
            chk("t3_rd_accept", bus_if.req_ready, 1);
        end
        rd(11'd20, 1'b0);
        chk("t3_credit_stall", bus_if.req_ready, 0);
        chk("t3_head_valid", bus_if.rsp_valid, 1);
        chk("t3_head_data", bus_if.rsp_rdata, 32'hCAFE_0010);
        rd(11'd20, 1'b0);
        chk("t3_still_stalled", bus_if.req_ready, 0);
        rd(11'd20, 1'b1);
        chk("t3_pop_at_zero_ready", bus_if.req_ready, 0);
        chk("t3_pop_at_zero_data", bus_if.rsp_rdata, 32'hCAFE_0010);
        rd(11'd20, 1'b1);
        chk("t3_fifth_accept", bus_if.req_ready, 1);
        chk("t3_pop_accept_data", bus_if.rsp_rdata, 32'hCAFE_0011);
        rd(11'd21, 1'b0);
        chk("t3_credit_one", bus_if.req_ready, 1);
        chk("t3_data_18", bus_if.rsp_rdata, 32'hCAFE_0012);
        nop(1'b0);
        chk("t3_credit_zero", bus_if.req_ready, 0);
        chk("t3_hold_18", bus_if.rsp_rdata, 32'hCAFE_0012);
        nop(1'b1);
        chk("t3_drain_ready", bus_if.req_ready, 0);
        chk("t3_drain_18", bus_if.rsp_rdata, 32'hCAFE_0012);
        nop(1'b1);
        chk("t3_ready_back", bus_if.req_ready, 1);
        chk("t3_drain_19", bus_if.rsp_rdata, 32'hCAFE_0013);
        nop(1'b1);
        chk("t3_drain_20", bus_if.rsp_rdata, 32'hCAFE_0014);
        nop(1'b1);
        chk("t3_drain_21", bus_if.rsp_rdata, 32'hCAFE_0015);
        nop(1'b1);
        chk("t3_empty", bus_if.rsp_valid, 0);
        chk("t3_idle", idle, 1);

        // cfg_pipen 0->1 with two reads in flight
        rd(11'd16, 1'b1);
        chk("t5_rd0_ready", bus_if.req_ready, 1);
        cfg_nxt = 1'b1;
        rd(11'd17, 1'b1);
        chk("t5_rd1_ready", bus_if.req_ready, 1);
        chk("t5_rd1_en", ram_en, 1);
        nop(1'b1);
        chk("t5_inflight_ready", bus_if.req_ready, 1);
        chk("t5_old_pipen", ram_pipen, 0);
        chk("t5_rsp0_valid", bus_if.rsp_valid, 1);
        chk("t5_rsp0_data", bus_if.rsp_rdata, 32'hCAFE_0010);
        nop(1'b1);
        chk("t5_update_ready", bus_if.req_ready, 0);
        chk("t5_update_pipen", ram_pipen, 0);
        chk("t5_rsp1_valid", bus_if.rsp_valid, 1);
        chk("t5_rsp1_data", bus_if.rsp_rdata, 32'hCAFE_0011);
        nop(1'b1);
        chk("t5_after_ready", bus_if.req_ready, 1);
        chk("t5_new_pipen", ram_pipen, 1);
        chk("t5_idle", idle, 1);

        // pipen=1: partial write merge, response 3 cycles after accept
        wr(11'd9, 32'h1111_1111, 4'hF);
        wr(11'd9, 32'h0000_EE00, 4'b0010);
        chk("t2_wem", ram_wem, 4'b0010);
        rd(11'd9, 1'b1);
        chk("t2_rd_accept", ram_en, 1);
        nop(1'b1);
        chk("t2_rsp_c1", bus_if.rsp_valid, 0);
        nop(1'b1);
        chk("t2_rsp_c2", bus_if.rsp_valid, 0);
        nop(1'b1);
        chk("t2_rsp_c3", bus_if.rsp_valid, 1);
        chk("t2_rsp_data", bus_if.rsp_rdata, 32'h1111_EE11);
        nop(1'b1);
        chk("t2_done", bus_if.rsp_valid, 0);
        chk("t2_idle", idle, 1);

        // Reset with three reads outstanding
        rd(11'd16, 1'b0);
        chk("t6_rd0", bus_if.req_ready, 1);
        rd(11'd17, 1'b0);
        chk("t6_rd1", bus_if.req_ready, 1);
        rd(11'd18, 1'b0);
        chk("t6_rd2", bus_if.req_ready, 1);
        nop(1'b0);
        chk("t6_pre_valid", bus_if.rsp_valid, 1);
        chk("t6_pre_data", bus_if.rsp_rdata, 32'hCAFE_0010);
        chk("t6_pre_busy", idle, 0);
        rst_nxt = 1'b0;
        cfg_nxt = 1'b0;
        nop(1'b0);
        chk("t6_rst_valid", bus_if.rsp_valid, 0);
        chk("t6_rst_idle", idle, 1);
        chk("t6_rst_ready", bus_if.req_ready, 0);
        chk("t6_rst_pipen", ram_pipen, 0);
        chk("t6_rst_data", bus_if.rsp_rdata, 0);
        rst_nxt = 1'b1;
        nop(1'b1);
        chk("t6_release_valid", bus_if.rsp_valid, 0);
        for (int i = 0; i < 5; i++) begin
            nop(1'b1);
            chk("t6_no_stale", bus_if.rsp_valid, 0);
            chk("t6_idle_after", idle, 1);
        end
        chk("t6_ready_after", bus_if.req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
